// File: rtl/row_deserializer.sv
// row_deserializer: reassembles LANES consecutive serial product words into one
// packed row and queues completed rows in a small FIFO for the writeback stage.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    serial product word, valid when in_load = 1
//   in_load    word strobe
//   row_data   head row of the FIFO; lane k at [k*WIDTH +: WIDTH], lane 0 first received
//   row_valid  FIFO non-empty
//   row_ready  consumer accepts head row when row_valid && row_ready
//   frame_err  one-cycle pulse after a partial group is aborted
//   overflow   sticky; a completed row was dropped because the FIFO was full
//   rows_out   count of accepted rows (wraps)
module row_deserializer #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_load,
    output logic [WIDTH*LANES-1:0] row_data,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic                   frame_err,
    output logic                   overflow,
    output logic [7:0]             rows_out
);

    localparam int unsigned ROW_W  = WIDTH * LANES;
    localparam int unsigned HOLD_W = WIDTH * (LANES - 1);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                frame_err_d;

    logic [ROW_W-1:0]    mem_q [DEPTH];
    logic [ROW_W-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_data_d;
    logic                row_valid_d;
    logic                overflow_d;
    logic [7:0]          rows_out_d;

    logic                push;
    logic                push_ok;
    logic                pop;
    logic [ROW_W-1:0]    push_row;

    // Collection state machine: gathers words into the hold register.
    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        hold_d      = hold_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        // Last word goes straight into the row alongside the held lanes.
        push_row    = {in_data, hold_q};

        case (state_q)
            IDLE: begin
                if (in_load) begin
                    hold_d[0 +: WIDTH] = in_data;
                    lane_cnt_d         = LANE_W'(1);
                    state_d            = COLLECT;
                end
            end
            COLLECT: begin
                if (in_load) begin
                    if (lane_cnt_q == LAST_LANE) begin
                        push       = 1'b1;
                        lane_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        for (int unsigned i = 0; i < LANES - 1; i++) begin
                            if (lane_cnt_q == LANE_W'(i)) begin
                                hold_d[i*WIDTH +: WIDTH] = in_data;
                            end
                        end
                        lane_cnt_d = lane_cnt_q + LANE_W'(1);
                    end
                end else begin
                    // Gap inside a group: drop the partial group.
                    lane_cnt_d  = '0;
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                lane_cnt_d = '0;
            end
        endcase
    end

    // Row FIFO next-state; the head is re-registered so row_data is a flop output.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow;
        rows_out_d = rows_out;

        pop     = row_valid && row_ready;
        // A pop frees the slot, so push into a full FIFO is fine when popping.
        push_ok = push && ((cnt_q != FULL_CNT) || pop);

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rows_out_d = rows_out + 8'(1);
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_row;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else if (push) begin
            overflow_d = 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        row_valid_d = (cnt_d != '0);
        row_data_d  = mem_d[rd_ptr_d];
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            hold_q     <= '0;
            frame_err  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            row_data   <= '0;
            row_valid  <= 1'b0;
            overflow   <= 1'b0;
            rows_out   <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            hold_q     <= hold_d;
            frame_err  <= frame_err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            row_data   <= row_data_d;
            row_valid  <= row_valid_d;
            overflow   <= overflow_d;
            rows_out   <= rows_out_d;
        end
    end

endmodule

// File: tb/tb_row_deserializer.sv
// tb_row_deserializer: directed and randomized checks of row_deserializer
// against a queue-based model of word grouping and the row FIFO.
module tb_row_deserializer;

    localparam int unsigned W  = 19;
    localparam int unsigned L  = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned RW = W * L;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_load;
    logic [RW-1:0] row_data;
    logic          row_valid;
    logic          row_ready;
    logic          frame_err;
    logic          overflow;
    logic [7:0]    rows_out;

    always #5 clk = ~clk;

    row_deserializer #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_load   (in_load),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .rows_out  (rows_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words of the open group, queued rows, flags.
    logic [W-1:0]  part [$];
    logic [RW-1:0] mq   [$];
    logic          m_ferr;
    logic          m_ovf;
    logic [7:0]    m_rows;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        mq.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        m_rows = 8'd0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, RW'(row_valid), RW'(mq.size() > 0));
        if (mq.size() > 0) chk({tag, "_data"}, row_data, mq[0]);
        chk({tag, "_ferr"}, RW'(frame_err), RW'(m_ferr));
        chk({tag, "_ovf"},  RW'(overflow),  RW'(m_ovf));
        chk({tag, "_rows"}, RW'(rows_out),  RW'(m_rows));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic cycle(input logic ld, input logic [W-1:0] d, input logic rdy, input string tag);
        logic          do_pop;
        logic          have_row;
        logic [RW-1:0] r;
        in_load   = ld;
        in_data   = d;
        row_ready = rdy;
        do_pop    = (mq.size() > 0) && rdy;
        have_row  = 1'b0;
        r         = '0;
        m_ferr    = 1'b0;
        if (ld) begin
            part.push_back(d);
            if (part.size() == L) begin
                for (int k = 0; k < L; k++) r[k*W +: W] = part[k];
                have_row = 1'b1;
                part.delete();
            end
        end else if (part.size() > 0) begin
            m_ferr = 1'b1;
            part.delete();
        end
        if (do_pop) begin
            void'(mq.pop_front());
            m_rows = m_rows + 8'd1;
        end
        if (have_row) begin
            if (mq.size() < D) mq.push_back(r);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic group(input logic rdy, input string tag);
        for (int j = 0; j < L; j++) cycle(1'b1, W'($urandom), rdy, tag);
    endtask

    initial begin
        logic [W-1:0] hv [4];
        logic brk;
        reset     = 1'b1;
        in_load   = 1'b0;
        in_data   = '0;
        row_ready = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", RW'(row_valid), '0);
        chk("rst_data",  row_data,       '0);
        chk("rst_ferr",  RW'(frame_err), '0);
        chk("rst_ovf",   RW'(overflow),  '0);
        chk("rst_rows",  RW'(rows_out),  '0);
        reset = 1'b1;

        // Basic row: valid one cycle after the 4th strobe.
        cycle(1'b1, 19'h00011, 1'b1, "t1");
        cycle(1'b1, 19'h00022, 1'b1, "t1");
        cycle(1'b1, 19'h00033, 1'b1, "t1");
        cycle(1'b1, 19'h00044, 1'b1, "t1");
        chk("t1_valid_now", RW'(row_valid), RW'(1));
        chk("t1_row", row_data, {19'h00044, 19'h00033, 19'h00022, 19'h00011});
        cycle(1'b0, '0, 1'b1, "t1");
        chk("t1_rows_one", RW'(rows_out), RW'(1));
        chk("t1_ferr_low", RW'(frame_err), '0);

        // Serializer cadence: 4 strobes, 4 idle, three times.
        for (int g = 0; g < 3; g++) begin
            group(1'b1, "t2");
            for (int j = 0; j < 4; j++) cycle(1'b0, '0, 1'b1, "t2");
        end
        chk("t2_rows_total", RW'(rows_out), RW'(4));
        chk("t2_ovf_low", RW'(overflow), '0);

        // Broken group then a clean one.
        cycle(1'b1, 19'h1, 1'b1, "t3");
        cycle(1'b1, 19'h2, 1'b1, "t3");
        cycle(1'b0, '0,    1'b1, "t3");
        chk("t3_ferr_pulse", RW'(frame_err), RW'(1));
        cycle(1'b1, 19'h5, 1'b1, "t3");
        chk("t3_ferr_single", RW'(frame_err), '0);
        cycle(1'b1, 19'h6, 1'b1, "t3");
        cycle(1'b1, 19'h7, 1'b1, "t3");
        cycle(1'b1, 19'h8, 1'b1, "t3");
        chk("t3_row", row_data, {19'h8, 19'h7, 19'h6, 19'h5});
        for (int j = 0; j < 3; j++) cycle(1'b0, '0, 1'b1, "t3");
        chk("t3_rows_total", RW'(rows_out), RW'(5));

        // Full FIFO, 4th strobe coincides with a pop: no overflow.
        group(1'b0, "t5");
        group(1'b0, "t5");
        for (int j = 0; j < 3; j++) cycle(1'b1, W'($urandom), 1'b0, "t5");
        cycle(1'b1, W'($urandom), 1'b1, "t5");
        chk("t5_ovf_low", RW'(overflow), '0);
        chk("t5_still_valid", RW'(row_valid), RW'(1));
        for (int j = 0; j < 4; j++) cycle(1'b0, '0, 1'b1, "t5");

        // Three groups while stalled: third is dropped, overflow sticks.
        for (int k = 0; k < 4; k++) hv[k] = W'($urandom);
        for (int k = 0; k < 4; k++) cycle(1'b1, hv[k], 1'b0, "t4");
        group(1'b0, "t4");
        group(1'b0, "t4");
        chk("t4_ovf_set", RW'(overflow), RW'(1));
        chk("t4_head_kept", row_data, {hv[3], hv[2], hv[1], hv[0]});
        for (int j = 0; j < 4; j++) cycle(1'b0, '0, 1'b1, "t4");
        chk("t4_ovf_sticky", RW'(overflow), RW'(1));
        chk("t4_drained", RW'(row_valid), '0);

        // Asynchronous reset mid-group with a row queued.
        group(1'b0, "t6");
        cycle(1'b1, W'($urandom), 1'b0, "t6");
        cycle(1'b1, W'($urandom), 1'b0, "t6");
        reset = 1'b0;
        #1;
        chk("t6_async_valid", RW'(row_valid), '0);
        chk("t6_async_ovf",   RW'(overflow),  '0);
        chk("t6_async_rows",  RW'(rows_out),  '0);
        model_reset();
        in_load = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) hv[k] = W'($urandom);
        for (int k = 0; k < 4; k++) cycle(1'b1, hv[k], 1'b1, "t6");
        chk("t6_fresh_row", row_data, {hv[3], hv[2], hv[1], hv[0]});
        cycle(1'b0, '0, 1'b1, "t6");

        // Randomized traffic: idle gaps, occasional broken groups, random backpressure.
        for (int g = 0; g < 120; g++) begin
            int n_idle;
            n_idle = int'($urandom_range(0, 3));
            for (int j = 0; j < n_idle; j++) cycle(1'b0, '0, 1'($urandom_range(0, 1)), "rnd");
            brk = 1'b0;
            for (int j = 0; j < L; j++) begin
                if (!brk) begin
                    if (j > 0 && $urandom_range(0, 9) == 0) begin
                        cycle(1'b0, '0, 1'($urandom_range(0, 1)), "rnd");
                        brk = 1'b1;
                    end else begin
                        cycle(1'b1, W'($urandom), 1'($urandom_range(0, 1)), "rnd");
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) cycle(1'b0, '0, 1'b1, "end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_deserializer.md
Name: row_deserializer

Overview:
- Receive side of the product serializer: takes the single-lane stream of 19-bit products (one word per strobe) and reassembles each group of LANES consecutive words into one packed row.
- Completed rows are queued in a small FIFO and handed to the C-register/writeback stage over a valid/ready handshake.
- Flags protocol errors: broken groups and row overflow.

Parameters:
- WIDTH, 19, bits per product word.
- LANES, 4, words per row.
- DEPTH, 2, row FIFO entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_data  input  WIDTH  serial product word.
- in_load  input  1  strobe; in_data is valid this cycle.
- row_data  output  WIDTH*LANES  head row; lane k occupies bits [k*WIDTH +: WIDTH]; lane 0 is the first word received.
- row_valid  output  1  FIFO non-empty.
- row_ready  input  1  consumer accepts the head row when row_valid && row_ready.
- frame_err  output  1  one-cycle pulse when a partial group is aborted.
- overflow  output  1  sticky; set when a completed row is dropped.
- rows_out  output  8  count of accepted rows; wraps 255 -> 0.

Behaviour:
- Reset (reset == 0, asynchronous):
  - lane_cnt = 0; FIFO empty.
  - row_valid = 0, row_data = 0, frame_err = 0, overflow = 0, rows_out = 0.
  - Any partial group or queued row is discarded, including mid-group.
- Collection state machine, two states:
  - IDLE (lane_cnt == 0):
    - in_load = 1: latch in_data into lane 0, go to COLLECT with lane_cnt = 1.
    - in_load = 0: stay.
  - COLLECT (1 <= lane_cnt <= LANES-1):
    - in_load = 1: latch in_data into lane lane_cnt, then lane_cnt + 1.
    - On the word landing in lane LANES-1: push {incoming word, lanes LANES-2..0} into the FIFO and return to IDLE. The final word bypasses the lane register.
    - in_load = 0: abort the group. lane_cnt -> 0, frame_err = 1 on the next cycle for exactly one cycle, nothing pushed.
  - Words in a group must therefore arrive on consecutive cycles. Idle cycles between groups are legal and unlimited.
- Latency: row_valid rises the cycle after the LANES-th strobe when the FIFO was empty.
- Row FIFO:
  - Registered output; row_data always shows the head entry and holds it stable while row_valid && !row_ready.
  - row_data is undefined-but-stable (no requirement) when row_valid = 0.
  - Pop on row_valid && row_ready; rows_out increments by 1 on each pop.
  - Push and pop in the same cycle are always legal, including when full: the count is unchanged and no overflow is raised.
  - Push while full without a pop: the new row is dropped, FIFO contents are unchanged, and overflow is set to 1 and held until reset.
  - Pop while empty cannot happen, because acceptance requires row_valid.
- Simultaneous events:
  - An abort and a new group start cannot coincide: an abort cycle has in_load = 0 by definition.
  - A group may start on the cycle immediately after a push.
- No arithmetic is performed on data. Words are stored bit-exact.

Test Plan:
- Reset, then in_load = 1 for 4 consecutive cycles with in_data = 0x00011, 0x00022, 0x00033, 0x00044, row_ready = 1 -> row_valid high 1 cycle after the 4th strobe; row_data = {0x00044, 0x00033, 0x00022, 0x00011}; rows_out = 1; frame_err = 0.
- Serializer pattern (4 strobes, 4 idle) repeated 3 times, row_ready = 1 -> three rows in arrival order; rows_out = 3; overflow = 0.
- Strobes 0x1, 0x2, one idle cycle, then 4 strobes 0x5..0x8 -> frame_err pulses exactly once, one cycle after the gap; the only row output is {0x8, 0x7, 0x6, 0x5}.
- row_ready = 0, three complete groups -> first two rows retained; overflow = 1 after the third; release row_ready -> first two rows delivered unchanged; overflow stays 1.
- FIFO full, and a 4th strobe lands in the same cycle as row_ready = 1 -> no overflow; FIFO count stays 2; the new row is delivered after the queued rows.
- Drop reset to 0 after 2 strobes of a group while 1 row is queued -> row_valid = 0 immediately (asynchronous); after release, a fresh 4-strobe group produces a row containing only the new words.
